// File: rtl/tpu_pkg.sv
// Shared opcode constants and sequencer state encoding for the TPU command path.
package tpu_pkg;

    localparam logic [2:0] OP_RESET       = 3'b111;
    localparam logic [2:0] OP_LOAD_INPUT  = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_LOAD_FIFO   = 3'b011;
    localparam logic [2:0] OP_MATMUL      = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } seq_state_t;

    // Only the two load opcodes carry a row stream after issue.
    function automatic logic is_stream_op(input logic [2:0] op);
        return (op == OP_LOAD_INPUT) || (op == OP_LOAD_WEIGHT);
    endfunction

endpackage

// File: rtl/tpu_cmd_sequencer_if.sv
// Host-side command and row-stream channels of the TPU command sequencer.
interface tpu_cmd_sequencer_if #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_MAT_WH   = 128
);
    localparam int DIM_W = $clog2(WIDTH_HEIGHT);
    localparam int SUB_W = $clog2(MAX_MAT_WH / WIDTH_HEIGHT);
    localparam int BUS_W = WIDTH_HEIGHT * DATA_WIDTH;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [DIM_W-1:0] cmd_dim_1;
    logic [DIM_W-1:0] cmd_dim_2;
    logic [DIM_W-1:0] cmd_dim_3;
    logic [7:0]       cmd_addr_1;
    logic [SUB_W-1:0] cmd_submat_row;
    logic [SUB_W-1:0] cmd_submat_col;
    logic             data_valid;
    logic             data_ready;
    logic [BUS_W-1:0] data_in;

    modport master (
        output cmd_valid, cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3,
               cmd_addr_1, cmd_submat_row, cmd_submat_col, data_valid, data_in,
        input  cmd_ready, data_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3,
               cmd_addr_1, cmd_submat_row, cmd_submat_col, data_valid, data_in,
        output cmd_ready, data_ready
    );

endinterface

// File: rtl/tpu_cmd_fifo.sv
// Power-of-two command queue with show-ahead head entry and occupancy count.
module tpu_cmd_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 29
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// Queues host TPU commands and issues them one at a time: start pulse, optional
// row stream into the input/weight memories, then wait for done or timeout.
module tpu_cmd_sequencer
    import tpu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_MAT_WH   = 128,
    parameter int CMD_DEPTH    = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [2:0]                                 cmd_opcode,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]            cmd_dim_1,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]            cmd_dim_2,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]            cmd_dim_3,
    input  logic [7:0]                                 cmd_addr_1,
    input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0] cmd_submat_row,
    input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0] cmd_submat_col,
    input  logic                                       data_valid,
    output logic                                       data_ready,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]         data_in,
    output logic                                       start,
    output logic [2:0]                                 opcode,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]            dim_1,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]            dim_2,
    output logic [$clog2(WIDTH_HEIGHT)-1:0]            dim_3,
    output logic [7:0]                                 addr_1,
    output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0] accum_table_submat_row_in,
    output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0] accum_table_submat_col_in,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]         inputMem_wr_data,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]         weightMem_wr_data,
    input  logic                                       done,
    input  logic                                       fifo_ready,
    output logic                                       busy,
    output logic [$clog2(CMD_DEPTH):0]                 cmd_count,
    output logic                                       timeout_err
);
    localparam int DIM_W   = $clog2(WIDTH_HEIGHT);
    localparam int SUB_W   = $clog2(MAX_MAT_WH / WIDTH_HEIGHT);
    localparam int ROW_W   = DIM_W + 1;
    localparam int BUS_W   = WIDTH_HEIGHT * DATA_WIDTH;
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 3 + 3 * DIM_W + 8 + 2 * SUB_W;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_en;

    logic [2:0]         head_opcode;
    logic [DIM_W-1:0]   head_dim_1, head_dim_2, head_dim_3;
    logic [7:0]         head_addr_1;
    logic [SUB_W-1:0]   head_sub_row, head_sub_col;

    seq_state_t         state_q, state_d;
    logic               start_q, start_d;
    logic               data_ready_q, data_ready_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [DIM_W-1:0]   dim_1_q, dim_1_d;
    logic [DIM_W-1:0]   dim_2_q, dim_2_d;
    logic [DIM_W-1:0]   dim_3_q, dim_3_d;
    logic [7:0]         addr_1_q, addr_1_d;
    logic [SUB_W-1:0]   sub_row_q, sub_row_d;
    logic [SUB_W-1:0]   sub_col_q, sub_col_d;
    logic [BUS_W-1:0]   in_wr_q, in_wr_d;
    logic [BUS_W-1:0]   wt_wr_q, wt_wr_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               done_seen_q, done_seen_d;
    logic               timeout_err_q, timeout_err_d;

    assign push_entry = {cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3,
                         cmd_addr_1, cmd_submat_row, cmd_submat_col};
    assign {head_opcode, head_dim_1, head_dim_2, head_dim_3,
            head_addr_1, head_sub_row, head_sub_col} = head_entry;

    tpu_cmd_fifo #(
        .DEPTH   (CMD_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_entry),
        .pop       (pop_en),
        .head_data (head_entry),
        .count     (cmd_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (cmd_count != '0) || (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        data_ready_d  = data_ready_q;
        opcode_d      = opcode_q;
        dim_1_d       = dim_1_q;
        dim_2_d       = dim_2_q;
        dim_3_d       = dim_3_q;
        addr_1_d      = addr_1_q;
        sub_row_d     = sub_row_q;
        sub_col_d     = sub_col_q;
        in_wr_d       = in_wr_q;
        wt_wr_d       = wt_wr_q;
        row_cnt_d     = row_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        done_seen_d   = done_seen_q;
        timeout_err_d = timeout_err_q;
        pop_en        = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_ready_d = 1'b0;
                done_seen_d  = 1'b0;
                if (!fifo_empty && fifo_ready) begin
                    pop_en    = 1'b1;
                    opcode_d  = head_opcode;
                    dim_1_d   = head_dim_1;
                    dim_2_d   = head_dim_2;
                    dim_3_d   = head_dim_3;
                    addr_1_d  = head_addr_1;
                    sub_row_d = head_sub_row;
                    sub_col_d = head_sub_col;
                    start_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                done_seen_d = done_seen_q || done;
                row_cnt_d   = '0;
                wait_cnt_d  = '0;
                if (is_stream_op(opcode_q)) begin
                    state_d      = STREAM;
                    data_ready_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            STREAM: begin
                done_seen_d = done_seen_q || done;
                if (data_valid) begin
                    if (opcode_q == OP_LOAD_INPUT) begin
                        in_wr_d = data_in;
                    end else begin
                        wt_wr_d = data_in;
                    end
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    // dim_1 is rows-minus-one, so the last row is the one at count dim_1.
                    if (row_cnt_q == {1'b0, dim_1_q}) begin
                        state_d      = WAIT;
                        data_ready_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (done || done_seen_q) begin
                    state_d     = IDLE;
                    done_seen_d = 1'b0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                    done_seen_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d      = IDLE;
                data_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            data_ready_q  <= 1'b0;
            opcode_q      <= '0;
            dim_1_q       <= '0;
            dim_2_q       <= '0;
            dim_3_q       <= '0;
            addr_1_q      <= '0;
            sub_row_q     <= '0;
            sub_col_q     <= '0;
            in_wr_q       <= '0;
            wt_wr_q       <= '0;
            row_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            done_seen_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            data_ready_q  <= data_ready_d;
            opcode_q      <= opcode_d;
            dim_1_q       <= dim_1_d;
            dim_2_q       <= dim_2_d;
            dim_3_q       <= dim_3_d;
            addr_1_q      <= addr_1_d;
            sub_row_q     <= sub_row_d;
            sub_col_q     <= sub_col_d;
            in_wr_q       <= in_wr_d;
            wt_wr_q       <= wt_wr_d;
            row_cnt_q     <= row_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            done_seen_q   <= done_seen_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign start                     = start_q;
    assign data_ready                = data_ready_q;
    assign opcode                    = opcode_q;
    assign dim_1                     = dim_1_q;
    assign dim_2                     = dim_2_q;
    assign dim_3                     = dim_3_q;
    assign addr_1                    = addr_1_q;
    assign accum_table_submat_row_in = sub_row_q;
    assign accum_table_submat_col_in = sub_col_q;
    assign inputMem_wr_data          = in_wr_q;
    assign weightMem_wr_data         = wt_wr_q;
    assign timeout_err               = timeout_err_q;

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Directed bench for tpu_cmd_sequencer: issue, streaming, queue limits, timeout, reset abort.
module tb_tpu_cmd_sequencer;
    import tpu_pkg::*;

    localparam int WH    = 16;
    localparam int DW    = 8;
    localparam int MW    = 128;
    localparam int DIM_W = 4;
    localparam int SUB_W = 3;
    localparam int BUS_W = WH * DW;

    logic             clk = 1'b0;
    logic             reset;
    logic             done;
    logic             fifo_ready;
    logic             start;
    logic [2:0]       opcode;
    logic [DIM_W-1:0] dim_1, dim_2, dim_3;
    logic [7:0]       addr_1;
    logic [SUB_W-1:0] sub_row, sub_col;
    logic [BUS_W-1:0] in_wr, wt_wr;
    logic             busy;
    logic [3:0]       cmd_count;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    tpu_cmd_sequencer_if #(.WIDTH_HEIGHT(WH), .DATA_WIDTH(DW), .MAX_MAT_WH(MW)) host ();

    tpu_cmd_sequencer #(
        .WIDTH_HEIGHT (WH),
        .DATA_WIDTH   (DW),
        .MAX_MAT_WH   (MW),
        .CMD_DEPTH    (8),
        .TIMEOUT      (1024)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .cmd_valid                 (host.cmd_valid),
        .cmd_ready                 (host.cmd_ready),
        .cmd_opcode                (host.cmd_opcode),
        .cmd_dim_1                 (host.cmd_dim_1),
        .cmd_dim_2                 (host.cmd_dim_2),
        .cmd_dim_3                 (host.cmd_dim_3),
        .cmd_addr_1                (host.cmd_addr_1),
        .cmd_submat_row            (host.cmd_submat_row),
        .cmd_submat_col            (host.cmd_submat_col),
        .data_valid                (host.data_valid),
        .data_ready                (host.data_ready),
        .data_in                   (host.data_in),
        .start                     (start),
        .opcode                    (opcode),
        .dim_1                     (dim_1),
        .dim_2                     (dim_2),
        .dim_3                     (dim_3),
        .addr_1                    (addr_1),
        .accum_table_submat_row_in (sub_row),
        .accum_table_submat_col_in (sub_col),
        .inputMem_wr_data          (in_wr),
        .weightMem_wr_data         (wt_wr),
        .done                      (done),
        .fifo_ready                (fifo_ready),
        .busy                      (busy),
        .cmd_count                 (cmd_count),
        .timeout_err               (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [BUS_W-1:0] row(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {WH{b}};
    endfunction

    task automatic set_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] a,
                           input logic [2:0] sr, input logic [2:0] sc);
        host.cmd_valid      = 1'b1;
        host.cmd_opcode     = op;
        host.cmd_dim_1      = d;
        host.cmd_dim_2      = d;
        host.cmd_dim_3      = d;
        host.cmd_addr_1     = a;
        host.cmd_submat_row = sr;
        host.cmd_submat_col = sc;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (start !== 1'b1 && n < 20);
        check({tag, "_start"}, 128'(start), 128'(1'b1));
    endtask

    initial begin
        int cyc;
        int k;
        reset           = 1'b1;
        done            = 1'b0;
        fifo_ready      = 1'b1;
        host.cmd_valid  = 1'b0;
        host.cmd_opcode = '0;
        host.cmd_dim_1  = '0;
        host.cmd_dim_2  = '0;
        host.cmd_dim_3  = '0;
        host.cmd_addr_1 = '0;
        host.cmd_submat_row = '0;
        host.cmd_submat_col = '0;
        host.data_valid = 1'b0;
        host.data_in    = '0;
        tick();
        tick();
        check("rst_start", 128'(start), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_count", 128'(cmd_count), 128'(0));
        check("rst_ready", 128'(host.cmd_ready), 128'(1));
        check("rst_dready", 128'(host.data_ready), 128'(0));
        check("rst_opcode", 128'(opcode), 128'(0));
        check("rst_in", 128'(in_wr), 128'(0));
        reset = 1'b0;
        tick();

        // OP_RESET: start for one cycle, WAIT, done -> idle
        set_cmd(OP_RESET, 4'h0, 8'h00, 3'd0, 3'd0);
        tick();
        host.cmd_valid = 1'b0;
        check("r_count1", 128'(cmd_count), 128'(1));
        check("r_busy1", 128'(busy), 128'(1));
        check("r_nostart", 128'(start), 128'(0));
        tick();
        check("r_start", 128'(start), 128'(1));
        check("r_opcode", 128'(opcode), 128'(3'b111));
        check("r_count0", 128'(cmd_count), 128'(0));
        tick();
        check("r_start_low", 128'(start), 128'(0));
        check("r_busy_wait", 128'(busy), 128'(1));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("r_busy_idle", 128'(busy), 128'(0));

        // OP_LOAD_INPUT: 16 continuous rows; done arrives early and is remembered
        set_cmd(OP_LOAD_INPUT, 4'hF, 8'h40, 3'd0, 3'd0);
        tick();
        host.cmd_valid = 1'b0;
        tick();
        check("li_start", 128'(start), 128'(1));
        check("li_opcode", 128'(opcode), 128'(OP_LOAD_INPUT));
        check("li_addr", 128'(addr_1), 128'(8'h40));
        host.data_valid = 1'b1;
        host.data_in    = row(8'hEE);
        tick();
        check("li_issue_ignored", 128'(in_wr), 128'(0));
        check("li_dready", 128'(host.data_ready), 128'(1));
        for (int r = 1; r <= 16; r++) begin
            host.data_in = row(r);
            done = (r == 3);
            tick();
            check($sformatf("li_row%0d", r), 128'(in_wr), 128'(row(r)));
        end
        host.data_valid = 1'b0;
        done = 1'b0;
        check("li_dready_off", 128'(host.data_ready), 128'(0));
        check("li_wt_hold", 128'(wt_wr), 128'(0));
        tick();
        check("li_done_seen_idle", 128'(busy), 128'(0));

        // OP_LOAD_WEIGHT with two stalled cycles
        set_cmd(OP_LOAD_WEIGHT, 4'hF, 8'h68, 3'd0, 3'd0);
        tick();
        host.cmd_valid = 1'b0;
        tick();
        check("lw_start", 128'(start), 128'(1));
        check("lw_addr", 128'(addr_1), 128'(8'h68));
        tick();
        cyc = 0;
        k   = 0;
        while (host.data_ready === 1'b1 && cyc < 40) begin
            cyc++;
            host.data_valid = (cyc != 5) && (cyc != 9);
            if (host.data_valid) begin
                k++;
                host.data_in = row(k);
            end
            tick();
            if (cyc == 5) check("lw_stall_hold", 128'(wt_wr), 128'(row(4)));
        end
        host.data_valid = 1'b0;
        check("lw_stream_cycles", 128'(cyc), 128'(18));
        check("lw_last_row", 128'(wt_wr), 128'(row(16)));
        check("lw_in_hold", 128'(in_wr), 128'(row(16)));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("lw_idle", 128'(busy), 128'(0));

        // queue fill with fifo_ready low, then drain in order
        fifo_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_cmd(OP_LOAD_FIFO, 4'h1, 8'(i + 1), 3'd0, 3'd0);
            tick();
            check($sformatf("q_count%0d", i + 1), 128'(cmd_count), 128'(i + 1));
        end
        check("q_full_ready", 128'(host.cmd_ready), 128'(0));
        set_cmd(OP_LOAD_FIFO, 4'h1, 8'd9, 3'd0, 3'd0);
        tick();
        host.cmd_valid = 1'b0;
        check("q_ninth_dropped", 128'(cmd_count), 128'(8));
        check("q_no_issue", 128'(start), 128'(0));
        fifo_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_start($sformatf("q_issue%0d", i + 1));
            check($sformatf("q_order%0d", i + 1), 128'(addr_1), 128'(i + 1));
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
        end
        tick();
        check("q_drained", 128'(cmd_count), 128'(0));
        check("q_idle", 128'(busy), 128'(0));

        // MATMUL without done -> timeout at WAIT cycle 1024, then next command issues
        set_cmd(OP_MATMUL, 4'hF, 8'h11, 3'b010, 3'b010);
        tick();
        set_cmd(OP_RESET, 4'h0, 8'h22, 3'd0, 3'd0);
        tick();
        host.cmd_valid = 1'b0;
        check("mm_start", 128'(start), 128'(1));
        check("mm_opcode", 128'(opcode), 128'(OP_MATMUL));
        check("mm_dim3", 128'(dim_3), 128'(4'hF));
        check("mm_subrow", 128'(sub_row), 128'(3'b010));
        check("mm_subcol", 128'(sub_col), 128'(3'b010));
        tick();
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 1100) begin
            tick();
            cyc++;
        end
        check("mm_timeout_cycle", 128'(cyc), 128'(1024));
        check("mm_timeout_err", 128'(timeout_err), 128'(1));
        check("mm_opcode_hold", 128'(opcode), 128'(OP_MATMUL));
        tick();
        check("mm_next_start", 128'(start), 128'(1));
        check("mm_next_addr", 128'(addr_1), 128'(8'h22));
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("mm_sticky", 128'(timeout_err), 128'(1));
        check("mm_idle", 128'(busy), 128'(0));

        // reset during STREAM row 7 with three queued commands
        set_cmd(OP_LOAD_INPUT, 4'hF, 8'h55, 3'd1, 3'd1);
        tick();
        host.cmd_valid = 1'b0;
        wait_start("ab");
        for (int i = 0; i < 3; i++) begin
            set_cmd(OP_LOAD_FIFO, 4'h2, 8'(8'hA0 + i), 3'd0, 3'd0);
            tick();
        end
        host.cmd_valid = 1'b0;
        check("ab_queued", 128'(cmd_count), 128'(3));
        host.data_valid = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            host.data_in = row(r);
            tick();
        end
        check("ab_row6", 128'(in_wr), 128'(row(6)));
        host.data_in = row(7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host.data_valid = 1'b0;
        check("ab_count", 128'(cmd_count), 128'(0));
        check("ab_busy", 128'(busy), 128'(0));
        check("ab_in", 128'(in_wr), 128'(0));
        check("ab_wt", 128'(wt_wr), 128'(0));
        check("ab_opcode", 128'(opcode), 128'(0));
        check("ab_addr", 128'(addr_1), 128'(0));
        check("ab_dims", 128'({dim_1, dim_2, dim_3}), 128'(0));
        check("ab_sub", 128'({sub_row, sub_col}), 128'(0));
        check("ab_timeout", 128'(timeout_err), 128'(0));
        check("ab_dready", 128'(host.data_ready), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ab_nostart%0d", i), 128'(start), 128'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
